// File: rtl/onehot_max_decoder.sv
// onehot_max_decoder
//   Receiving end of the one-hot max-select encoding. The code says which
//   operand won: 3'b100 means a, 3'b010 means b and 3'b001 means c. The
//   block decodes the code back to a value and an index and cross-checks it
//   against the operands. It also keeps saturating per-winner and error
//   counters for the status path.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake for {a, b, c, code}
//   a, b, c           operands the code refers to (W bits, unsigned)
//   code              one-hot winner code (bit2 = a, bit1 = b, bit0 = c)
//   out_valid/out_ready output handshake for the decoded result
//   out_val, out_idx  decoded winner value and index (3 = invalid code)
//   bad_code          code was not one-hot
//   mismatch          code is one-hot but does not name the true maximum
//   clear             synchronous clear of all counters
//   win_cnt_a/b/c     accepted clean tokens per winner (saturating)
//   err_cnt           accepted tokens with bad_code or mismatch (saturating)
module onehot_max_decoder #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [2:0]       code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_val,
    output logic [1:0]       out_idx,
    output logic             bad_code,
    output logic             mismatch,
    input  logic             clear,
    output logic [CNT_W-1:0] win_cnt_a,
    output logic [CNT_W-1:0] win_cnt_b,
    output logic [CNT_W-1:0] win_cnt_c,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } obuf_state_e;

    obuf_state_e      state_q, state_d;
    logic [W-1:0]     val_q, val_d;
    logic [1:0]       idx_q, idx_d;
    logic             bad_q, bad_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] win_a_q, win_a_d;
    logic [CNT_W-1:0] win_b_q, win_b_d;
    logic [CNT_W-1:0] win_c_q, win_c_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic             accept;
    logic [2:0]       exp_code;
    logic [W-1:0]     dec_val;
    logic [1:0]       dec_idx;
    logic             dec_bad;
    logic             dec_mis;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Single output register with no skid buffer: a new token may enter
    // whenever the register is empty or is being drained this same cycle.
    assign in_ready = (state_q == S_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // Expected code: unsigned maximum, ties resolved a > b > c.
    always_comb begin
        exp_code = 3'b001;
        if (a >= b && a >= c) begin
            exp_code = 3'b100;
        end else if (b >= c) begin
            exp_code = 3'b010;
        end
    end

    // Decode the received code. A one-hot code always selects its operand,
    // even when it disagrees with the expected code.
    always_comb begin
        dec_val = '0;
        dec_idx = 2'd3;
        dec_bad = 1'b0;
        case (code)
            3'b100: begin
                dec_val = a;
                dec_idx = 2'd0;
            end
            3'b010: begin
                dec_val = b;
                dec_idx = 2'd1;
            end
            3'b001: begin
                dec_val = c;
                dec_idx = 2'd2;
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
        dec_mis = !dec_bad && (code != exp_code);
    end

    // Output buffer state and held result.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        mis_d   = mis_q;
        if (accept) begin
            state_d = S_FULL;
            val_d   = dec_val;
            idx_d   = dec_idx;
            bad_d   = dec_bad;
            mis_d   = dec_mis;
        end else if (state_q == S_FULL && out_ready) begin
            state_d = S_EMPTY;
        end
    end

    // Counters: clear has priority over the token accepted in the same
    // cycle, so that token is presented but never counted.
    always_comb begin
        win_a_d = win_a_q;
        win_b_d = win_b_q;
        win_c_d = win_c_q;
        err_d   = err_q;
        if (clear) begin
            win_a_d = '0;
            win_b_d = '0;
            win_c_d = '0;
            err_d   = '0;
        end else if (accept) begin
            if (dec_bad || dec_mis) begin
                err_d = sat_inc(err_q);
            end else begin
                case (dec_idx)
                    2'd0:    win_a_d = sat_inc(win_a_q);
                    2'd1:    win_b_d = sat_inc(win_b_q);
                    2'd2:    win_c_d = sat_inc(win_c_q);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            val_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            mis_q   <= 1'b0;
            win_a_q <= '0;
            win_b_q <= '0;
            win_c_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            mis_q   <= mis_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            win_c_q <= win_c_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_val   = val_q;
    assign out_idx   = idx_q;
    assign bad_code  = bad_q;
    assign mismatch  = mis_q;
    assign win_cnt_a = win_a_q;
    assign win_cnt_b = win_b_q;
    assign win_cnt_c = win_c_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_onehot_max_decoder.sv
module tb_onehot_max_decoder;

    localparam int W   = 3;
    localparam int CW  = 8;
    localparam int CWS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, out_ready, clear;
    logic [W-1:0]  a, b, c;
    logic [2:0]    code;

    logic          in_ready, out_valid, bad_code, mismatch;
    logic [W-1:0]  out_val;
    logic [1:0]    out_idx;
    logic [CW-1:0] win_cnt_a, win_cnt_b, win_cnt_c, err_cnt;

    logic           in_ready_s, out_valid_s, bad_code_s, mismatch_s;
    logic [W-1:0]   out_val_s;
    logic [1:0]     out_idx_s;
    logic [CWS-1:0] win_cnt_a_s, win_cnt_b_s, win_cnt_c_s, err_cnt_s;

    onehot_max_decoder #(.W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .code(code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_idx(out_idx),
        .bad_code(bad_code), .mismatch(mismatch), .clear(clear),
        .win_cnt_a(win_cnt_a), .win_cnt_b(win_cnt_b), .win_cnt_c(win_cnt_c),
        .err_cnt(err_cnt)
    );

    onehot_max_decoder #(.W(W), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .c(c), .code(code),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_val(out_val_s), .out_idx(out_idx_s),
        .bad_code(bad_code_s), .mismatch(mismatch_s), .clear(clear),
        .win_cnt_a(win_cnt_a_s), .win_cnt_b(win_cnt_b_s), .win_cnt_c(win_cnt_c_s),
        .err_cnt(err_cnt_s)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: held result plus counters kept as plain integers,
    // index 0..2 = wins for a/b/c, index 3 = errors.
    bit mv;
    int mval, midx, mbad, mmis;
    int cnt[4];
    int cnts[4];
    bit last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index of the largest operand, first one wins on a tie.
    function automatic int winner(input int x, input int y, input int z);
        int m;
        m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        if (x == m) return 0;
        if (y == m) return 1;
        return 2;
    endfunction

    function automatic int sat_add(input int v, input int lim);
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    task automatic step();
        bit er, acc;
        int ops[3];
        int id, slot;
        @(negedge clk);
        er = !mv || out_ready;
        chk("in_ready", in_ready, er);
        chk("in_ready_s", in_ready_s, er);
        @(posedge clk);
        acc = in_valid && er;
        last_acc = acc;
        if (rst) begin
            mv = 0; mval = 0; midx = 0; mbad = 0; mmis = 0;
            cnt = '{default: 0};
            cnts = '{default: 0};
        end else begin
            if (acc) begin
                ops = '{int'(a), int'(b), int'(c)};
                if ($countones(code) != 1) begin
                    mval = 0; midx = 3; mbad = 1; mmis = 0;
                end else begin
                    id = (code == 3'b100) ? 0 : (code == 3'b010) ? 1 : 2;
                    mval = ops[id];
                    midx = id;
                    mbad = 0;
                    mmis = (id != winner(ops[0], ops[1], ops[2])) ? 1 : 0;
                end
                mv = 1;
            end else if (mv && out_ready) begin
                mv = 0;
            end
            if (clear) begin
                cnt = '{default: 0};
                cnts = '{default: 0};
            end else if (acc) begin
                slot = (mbad != 0 || mmis != 0) ? 3 : midx;
                cnt[slot]  = sat_add(cnt[slot], 255);
                cnts[slot] = sat_add(cnts[slot], 3);
            end
        end
        #1;
        chk("out_valid", out_valid, mv);
        chk("out_val", out_val, mval);
        chk("out_idx", out_idx, midx);
        chk("bad_code", bad_code, mbad);
        chk("mismatch", mismatch, mmis);
        chk("win_cnt_a", win_cnt_a, cnt[0]);
        chk("win_cnt_b", win_cnt_b, cnt[1]);
        chk("win_cnt_c", win_cnt_c, cnt[2]);
        chk("err_cnt", err_cnt, cnt[3]);
        chk("out_valid_s", out_valid_s, mv);
        chk("out_val_s", out_val_s, mval);
        chk("win_cnt_a_s", win_cnt_a_s, cnts[0]);
        chk("win_cnt_b_s", win_cnt_b_s, cnts[1]);
        chk("win_cnt_c_s", win_cnt_c_s, cnts[2]);
        chk("err_cnt_s", err_cnt_s, cnts[3]);
    endtask

    // Present one token and step until it is accepted (bounded).
    task automatic send(input int ta, input int tb, input int tc, input int tcode,
                        output int cycles);
        a = W'(ta); b = W'(tb); c = W'(tc); code = 3'(tcode);
        in_valid = 1'b1;
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!last_acc && cycles < 16);
        chk("send_accepted", last_acc, 1'b1);
    endtask

    initial begin
        int n;
        int w, r;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        a = '0; b = '0; c = '0; code = '0;
        mv = 0; mval = 0; midx = 0; mbad = 0; mmis = 0;
        cnt = '{default: 0}; cnts = '{default: 0}; last_acc = 0;

        step(); step();
        rst = 1'b0;

        // Post-reset decode
        send(5, 3, 1, 3'b100, n);
        chk("first_val", out_val, 5);
        chk("first_cnt_a", win_cnt_a, 1);

        // Tie priority
        send(4, 4, 2, 3'b100, n);
        chk("tie_clean_mis", mismatch, 0);
        send(4, 4, 2, 3'b010, n);
        chk("tie_b_mis", mismatch, 1);
        chk("tie_b_idx", out_idx, 1);
        chk("tie_b_cnt_b", win_cnt_b, 0);
        in_valid = 1'b0;

        // Malformed codes after a counter clear
        clear = 1'b1; step(); clear = 1'b0;
        send(1, 2, 3, 3'b000, n);
        chk("bad0_idx", out_idx, 3);
        send(1, 2, 3, 3'b110, n);
        chk("bad2_flag", bad_code, 1);
        chk("bad_err_cnt", err_cnt, 2);
        in_valid = 1'b0;
        step();

        // Backpressure: first token held, later tokens blocked
        out_ready = 1'b0;
        send(6, 1, 2, 3'b100, n);
        a = 3'd1; b = 3'd7; c = 3'd0; code = 3'b010;
        step(); step();
        chk("stall_held_val", out_val, 6);
        out_ready = 1'b1;
        send(1, 7, 0, 3'b010, n);
        chk("release_lat", n, 1);
        send(0, 2, 5, 3'b001, n);
        chk("throughput", n, 1);
        chk("third_val", out_val, 5);
        in_valid = 1'b0;
        step();

        // Saturation on the narrow instance, then clear during an accept
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(7, 2, 1, 3'b100, n);
            if (i == 2) chk("sat_after3", win_cnt_a_s, 3);
        end
        chk("sat_after5", win_cnt_a_s, 3);
        clear = 1'b1;
        send(7, 2, 1, 3'b100, n);
        clear = 1'b0;
        chk("clear_acc_cnt", win_cnt_a, 0);
        chk("clear_acc_valid", out_valid, 1);
        in_valid = 1'b0;
        step();

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(63) == 0);
            clear     = ($urandom_range(31) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            r = $urandom_range(3);
            w = winner(int'(a), int'(b), int'(c));
            if (r < 2)       code = 3'(3'b100 >> w);
            else if (r == 2) code = 3'(3'b100 >> $urandom_range(2));
            else             code = 3'($urandom);
            step();
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Reset mid-stream with a stalled result
        out_ready = 1'b0;
        send(3, 2, 1, 3'b100, n);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_cnt_a", win_cnt_a, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
